// File: rtl/hazard_check.sv
// Read-after-write hazard checker between decode and register-read.
// Optional HAZARD_STALL_COUNT_EN adds a saturating stall-cycle counter.
module hazard_check #(
    parameter int LATENCY = 3
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        flushBack_i,
    input  logic        enable_i,
    input  logic [6:0]  opcode_i,
    input  logic [1:0]  functionType_i,
    input  logic [4:0]  primOperand_i,
    input  logic [15:0] secOperand_i,
    input  logic        pRead_i,
    input  logic        pWrite_i,
    input  logic        sRead_i,
    output logic        stall_o,
    output logic        enable_o,
    output logic [6:0]  opcode_o,
    output logic [1:0]  functionType_o,
    output logic [4:0]  primOperand_o,
    output logic [15:0] secOperand_o,
    output logic        pRead_o,
    output logic        pWrite_o,
    output logic        sRead_o,
`ifdef HAZARD_STALL_COUNT_EN
    output logic [15:0] stallCount_o,
`endif
    output logic        overflow_o
);

    localparam int WIN = LATENCY - 1;

    typedef enum logic {
        PASS,
        HOLD
    } state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [1:0]  ftype;
        logic [4:0]  prim;
        logic [15:0] sec;
        logic        pread;
        logic        pwrite;
        logic        sread;
    } instr_t;

    state_t              state_q, state_d;
    instr_t              hold_q, hold_d;
    instr_t              out_q, out_d;
    instr_t              in_instr, cand;
    logic                enable_q, enable_d;
    logic                overflow_q, overflow_d;
    logic [WIN-1:0]      win_valid_q, win_valid_d;
    logic [WIN-1:0][4:0] win_dest_q, win_dest_d;
    logic                cand_valid, hazard, issue;

    assign in_instr = {opcode_i, functionType_i, primOperand_i,
                       secOperand_i, pRead_i, pWrite_i, sRead_i};

    // A held instruction always outranks the input port.
    always_comb begin
        cand_valid = (state_q == HOLD) || enable_i;
        cand       = (state_q == HOLD) ? hold_q : in_instr;
        hazard     = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (win_valid_q[i] &&
                ((cand.pread && cand.prim == win_dest_q[i]) ||
                 (cand.sread && cand.sec[4:0] == win_dest_q[i]))) begin
                hazard = 1'b1;
            end
        end
        issue = cand_valid && !hazard;
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        out_d      = out_q;
        enable_d   = 1'b0;
        overflow_d = overflow_q;

        for (int i = WIN - 1; i > 0; i--) begin
            win_valid_d[i] = win_valid_q[i-1];
            win_dest_d[i]  = win_dest_q[i-1];
        end
        win_valid_d[0] = issue && cand.pwrite;
        win_dest_d[0]  = cand.prim;

        unique case (state_q)
            PASS: begin
                if (issue) begin
                    out_d    = cand;
                    enable_d = 1'b1;
                end else if (cand_valid) begin
                    hold_d  = cand;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (enable_i) begin
                    overflow_d = 1'b1;
                end
                if (issue) begin
                    out_d    = cand;
                    enable_d = 1'b1;
                    state_d  = PASS;
                end
            end
            default: state_d = PASS;
        endcase

        if (flushBack_i) begin
            state_d     = PASS;
            hold_d      = '0;
            out_d       = out_q;
            enable_d    = 1'b0;
            overflow_d  = overflow_q;
            win_valid_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= PASS;
            hold_q      <= '0;
            out_q       <= '0;
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            win_valid_q <= '0;
            win_dest_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            win_valid_q <= win_valid_d;
            win_dest_q  <= win_dest_d;
        end
    end

    assign stall_o        = (state_q == HOLD);
    assign enable_o       = enable_q;
    assign overflow_o     = overflow_q;
    assign opcode_o       = out_q.opcode;
    assign functionType_o = out_q.ftype;
    assign primOperand_o  = out_q.prim;
    assign secOperand_o   = out_q.sec;
    assign pRead_o        = out_q.pread;
    assign pWrite_o       = out_q.pwrite;
    assign sRead_o        = out_q.sread;

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == HOLD && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_check.sv
// Bench for hazard_check: directed scenarios plus random traffic
// checked against an issue-time model of register write spacing.
module tb_hazard_check;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  op = '0;
    logic [1:0]  ft = '0;
    logic [4:0]  prim = '0;
    logic [15:0] sec = '0;
    logic        pr = 1'b0;
    logic        pw = 1'b0;
    logic        sr = 1'b0;

    logic        stall_o, enable_o, pRead_o, pWrite_o, sRead_o, overflow_o;
    logic [6:0]  opcode_o;
    logic [1:0]  functionType_o;
    logic [4:0]  primOperand_o;
    logic [15:0] secOperand_o;
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    hazard_check #(.LATENCY(LAT)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .flushBack_i   (flush),
        .enable_i      (en),
        .opcode_i      (op),
        .functionType_i(ft),
        .primOperand_i (prim),
        .secOperand_i  (sec),
        .pRead_i       (pr),
        .pWrite_i      (pw),
        .sRead_i       (sr),
        .stall_o       (stall_o),
        .enable_o      (enable_o),
        .opcode_o      (opcode_o),
        .functionType_o(functionType_o),
        .primOperand_o (primOperand_o),
        .secOperand_o  (secOperand_o),
        .pRead_o       (pRead_o),
        .pWrite_o      (pWrite_o),
        .sRead_o       (sRead_o),
`ifdef HAZARD_STALL_COUNT_EN
        .stallCount_o  (stall_count),
`endif
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [1:0]  ft;
        logic [4:0]  prim;
        logic [15:0] sec;
        logic        pr;
        logic        pw;
        logic        sr;
    } ins_t;

    int   checks = 0;
    int   passed = 0;
    int   fails = 0;
    int   t = 0;
    int   last_wr[32];
    ins_t m_out, m_hold;
    bit   m_hv, m_en, m_ovf;
    int   m_cnt;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a read may issue once LAT edges have passed since the
    // last issued write of that register.
    function automatic bit ready(ins_t c);
        bit ok = 1'b1;
        if (c.pr && (t - last_wr[c.prim]) < LAT) ok = 1'b0;
        if (c.sr && (t - last_wr[c.sec[4:0]]) < LAT) ok = 1'b0;
        return ok;
    endfunction

    task automatic clear_writes();
        for (int r = 0; r < 32; r++) last_wr[r] = -1000;
    endtask

    task automatic model_edge();
        ins_t c;
        bit   cv, from_hold;
        if (rst) begin
            m_out = '0;
            m_hold = '0;
            m_hv = 0;
            m_en = 0;
            m_ovf = 0;
            m_cnt = 0;
            clear_writes();
        end else begin
            if (m_hv && m_cnt < 65535) m_cnt++;
            if (flush) begin
                m_en = 0;
                m_hv = 0;
                clear_writes();
            end else begin
                from_hold = m_hv;
                c = m_hv ? m_hold : ins_t'({op, ft, prim, sec, pr, pw, sr});
                cv = m_hv || en;
                if (m_hv && en) m_ovf = 1;
                m_en = 0;
                if (cv && ready(c)) begin
                    m_en = 1;
                    m_out = c;
                    m_hv = 0;
                    if (c.pw) last_wr[c.prim] = t;
                end else if (cv && !from_hold) begin
                    m_hold = c;
                    m_hv = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        model_edge();
        #1;
        chk("enable", enable_o, m_en);
        chk("stall", stall_o, m_hv);
        chk("overflow", overflow_o, m_ovf);
        chk("data", {opcode_o, functionType_o, primOperand_o, secOperand_o,
                     pRead_o, pWrite_o, sRead_o}, m_out);
`ifdef HAZARD_STALL_COUNT_EN
        chk("stall_count", stall_count, m_cnt);
`endif
    endtask

    task automatic drive(bit e, logic [4:0] p, logic [15:0] s,
                         bit r1, bit w1, bit r2, logic [6:0] o);
        en = e;
        prim = p;
        sec = s;
        pr = r1;
        pw = w1;
        sr = r2;
        op = o;
        ft = 2'b01;
    endtask

    task automatic idle(int n);
        en = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        en = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    // add r3 then add r3,r3: enable 1,0,0,1 with two stall cycles
    task automatic scen_raw(string tag);
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        chk({tag, "_e1"}, enable_o, 1'b1);
        drive(1, 5'd3, 16'h0003, 1, 1, 0, 7'h33);
        tick();
        chk({tag, "_e2"}, enable_o, 1'b0);
        chk({tag, "_s2"}, stall_o, 1'b1);
        en = 0;
        tick();
        chk({tag, "_e3"}, enable_o, 1'b0);
        chk({tag, "_s3"}, stall_o, 1'b1);
        tick();
        chk({tag, "_e4"}, enable_o, 1'b1);
        chk({tag, "_s4"}, stall_o, 1'b0);
        idle(2);
    endtask

    initial begin
        clear_writes();
        do_reset();
        chk("rst_en", enable_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_prim", primOperand_o, 5'd0);

        scen_raw("raw");

        // add r3; add r5; store r3
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        chk("st_e1", enable_o, 1'b1);
        drive(1, 5'd5, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        chk("st_e2", enable_o, 1'b1);
        drive(1, 5'd3, 16'h0010, 1, 0, 0, 7'h23);
        tick();
        chk("st_e3", enable_o, 1'b0);
        en = 0;
        tick();
        chk("st_e4", enable_o, 1'b1);
        chk("st_op", opcode_o, 7'h23);
        idle(2);

        // reg-reg read through the secondary operand
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        drive(1, 5'd4, 16'h0003, 0, 1, 1, 7'h33);
        tick();
        chk("sr_s1", stall_o, 1'b1);
        en = 0;
        tick();
        chk("sr_s2", stall_o, 1'b1);
        tick();
        chk("sr_e", enable_o, 1'b1);
        idle(2);
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        drive(1, 5'd4, 16'h0003, 0, 1, 0, 7'h33);
        tick();
        chk("nosr_e", enable_o, 1'b1);
        chk("nosr_s", stall_o, 1'b0);
        // rewrite of own window register without reads
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h13);
        tick();
        chk("self_e", enable_o, 1'b1);
        chk("self_s", stall_o, 1'b0);
        idle(2);

        // flush while holding
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        drive(1, 5'd3, 16'h0000, 1, 1, 0, 7'h55);
        tick();
        chk("fl_hold", stall_o, 1'b1);
        en = 0;
        flush = 1;
        tick();
        flush = 0;
        chk("fl_e", enable_o, 1'b0);
        chk("fl_s", stall_o, 1'b0);
        drive(1, 5'd7, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        chk("fl_next_e", enable_o, 1'b1);
        chk("fl_next_p", primOperand_o, 5'd7);
        idle(3);

        // input presented during a stall
        drive(1, 5'd3, 16'h0000, 0, 1, 0, 7'h33);
        tick();
        drive(1, 5'd3, 16'h0abc, 1, 0, 0, 7'h41);
        tick();
        drive(1, 5'd9, 16'h1234, 0, 1, 0, 7'h7f);
        tick();
        chk("ov_set", overflow_o, 1'b1);
        en = 0;
        tick();
        chk("ov_issue_op", opcode_o, 7'h41);
        chk("ov_issue_sec", secOperand_o, 16'h0abc);
        idle(3);
        chk("ov_sticky", overflow_o, 1'b1);
        do_reset();
        chk("ov_clear", overflow_o, 1'b0);

        scen_raw("c1");
        scen_raw("c2");
        scen_raw("c3");
`ifdef HAZARD_STALL_COUNT_EN
        chk("cnt6", stall_count, 16'd6);
        do_reset();
        chk("cnt0", stall_count, 16'd0);
`endif

        // random traffic, narrow register range to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            en = m_hv ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 2) != 0);
            op = 7'($urandom);
            ft = 2'($urandom);
            prim = 5'($urandom_range(0, 7));
            sec = {11'($urandom), 5'($urandom_range(0, 7))};
            pr = 1'($urandom);
            pw = 1'($urandom);
            sr = 1'($urandom);
            tick();
        end
        rst = 0;
        flush = 0;
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_check.md
HAZARD_CHECK -- requirements
Module: hazard_check

Interface
REQ-001 Parameter LATENCY, default 3: minimum issue spacing in cycles between a register write and a dependent read; legal range 2..8.
REQ-002 Port clock_i  in  1  sole clock, all state updates on its rising edge.
REQ-003 Port reset_i  in  1  synchronous, active-high reset.
REQ-004 Port flushBack_i  in  1  pipeline flush.
REQ-005 Ports enable_i 1 / opcode_i 7 / functionType_i 2 / primOperand_i 5 / secOperand_i 16 / pRead_i 1 / pWrite_i 1 / sRead_i 1  in  decoded instruction from the decode stage.
REQ-006 Port stall_o  out  1  high while the hold buffer is occupied; upstream presents no new instruction while high.
REQ-007 Ports enable_o 1 / opcode_o 7 / functionType_o 2 / primOperand_o 5 / secOperand_o 16 / pRead_o 1 / pWrite_o 1 / sRead_o 1  out  registered instruction to register-read stage.
REQ-008 Port overflow_o  out  1  sticky error: instruction arrived while stall_o high.

Function
REQ-009 Write window: LATENCY-1 entries {valid, dest[4:0]}, shifted every cycle; entry 0 holds the instruction issued at the previous edge.
REQ-010 Candidate each cycle: hold buffer if valid, else input when enable_i=1, else none.
REQ-011 Hazard: candidate pRead=1 with primOperand matching any valid window dest, or sRead=1 with secOperand[4:0] matching any valid window dest.
REQ-012 No candidate or hazard: next edge enable_o<=0, data outputs keep previous values, window shifts in valid=0.
REQ-013 Candidate without hazard: next edge all outputs <= candidate fields, enable_o<=1, window shifts in {pWrite, primOperand}; hold buffer cleared if it was the source.
REQ-014 Input candidate with hazard: captured into hold buffer at next edge; stall_o is hold-valid, registered.
REQ-015 Hazard-free latency 1 cycle; issued write and dependent read separated by >= LATENCY edges, never more than needed.
REQ-016 State machine: PASS (hold empty) -> HOLD on REQ-014; HOLD -> PASS on hold issue; HOLD persists otherwise.
REQ-017 enable_i=1 while in HOLD: input dropped, overflow_o<=1, hold content unchanged.
REQ-018 Nop (pRead=sRead=0) never stalls; pWrite=0 entries never create hazards.
REQ-019 Instruction depending on its own window entry only (no pRead/sRead): issues with no stall.
REQ-020 flushBack_i=1 (reset_i=0): next edge enable_o<=0, hold cleared, all window entries invalid, stall_o<=0; input that cycle discarded; overflow_o unchanged.

Reset
REQ-021 reset_i=1 at an edge: enable_o, stall_o, overflow_o, pRead_o, pWrite_o, sRead_o <= 0; opcode_o, functionType_o, primOperand_o, secOperand_o <= 0; window and hold cleared; state PASS.
REQ-022 reset_i has priority over flushBack_i and enable_i; asserting it mid-stall discards the held instruction.

Configuration
REQ-023 Macro HAZARD_STALL_COUNT_EN defined: extra output stallCount_o (16 bits), reset to 0, incremented each cycle stall_o=1, saturating at 16'hFFFF, cleared by reset_i only.
REQ-024 Macro undefined: stallCount_o absent, no counter logic; all other behaviour identical.

Verification (LATENCY=3)
REQ-025 Reset, then add r3 (pWrite, prim 3) then add r3,r3 (pRead) back-to-back -> enable_o edges 1,0,0,1; stall_o high 2 cycles.
REQ-026 add r3; add r5 (prim 5, no r3 reads); store r3 (pRead prim 3) -> enable_o 1,1,0,1; store issues at edge 4.
REQ-027 reg-reg add r4, sec 16'h0003 (sRead) after write r3 -> stalled 2 cycles; same with sRead=0 -> no stall.
REQ-028 Hazard held, flushBack_i pulsed -> enable_o 0, stall_o 0 next cycle, held instruction never issued, next non-dependent instruction issues in 1 cycle.
REQ-029 enable_i=1 during stall_o=1 -> overflow_o=1 until reset_i; held instruction issues unchanged.
REQ-030 With HAZARD_STALL_COUNT_EN, scenario REQ-025 repeated 3 times -> stallCount_o=6; reset_i -> 0.
